// File: rtl/vlc_pkg.sv
// Shared types and constants for the vehicle lamp controller and its decoder.
package vlc_pkg;

  // Operating mode as seen on the lamp controller and decoder ports.
  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } vlc_mode_t;

  // Decoder tracking state; ACQ means no mode is currently being followed.
  typedef enum logic [1:0] {
    DEC_ACQ,
    DEC_LEFT,
    DEC_RIGHT,
    DEC_HAZ
  } vlc_dec_state_t;

  // Per-side lamp patterns; bit0 is the inner lamp, which lights first.
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_S1  = 3'b001;
  localparam logic [2:0] LAMP_S2  = 3'b011;
  localparam logic [2:0] LAMP_S3  = 3'b111;

  // Full six-lamp pattern, packed as {left, right}.
  typedef logic [5:0] vlc_pattern_t;

  localparam vlc_pattern_t PAT_OFF = {LAMP_OFF, LAMP_OFF};
  localparam vlc_pattern_t PAT_L1  = {LAMP_S1, LAMP_OFF};
  localparam vlc_pattern_t PAT_R1  = {LAMP_OFF, LAMP_S1};
  localparam vlc_pattern_t PAT_HAZ = {LAMP_S3, LAMP_S3};

  // Legal successor of a non-OFF pattern while following a mode.
  // The final step of every sequence returns to OFF.
  function automatic vlc_pattern_t next_step(input vlc_dec_state_t st,
                                             input vlc_pattern_t   cur);
    logic [2:0] lamps;
    logic [2:0] nxt;
    lamps = (st == DEC_RIGHT) ? cur[2:0] : cur[5:3];
    case (lamps)
      LAMP_S1: nxt = LAMP_S2;
      LAMP_S2: nxt = LAMP_S3;
      default: nxt = LAMP_OFF;
    endcase
    case (st)
      DEC_LEFT:  next_step = {nxt, LAMP_OFF};
      DEC_RIGHT: next_step = {LAMP_OFF, nxt};
      default:   next_step = PAT_OFF;
    endcase
  endfunction

  // Reported mode for a decoder state; ACQ reads as IDLE.
  function automatic vlc_mode_t state_to_mode(input vlc_dec_state_t st);
    case (st)
      DEC_LEFT:  state_to_mode = MODE_LEFT;
      DEC_RIGHT: state_to_mode = MODE_RIGHT;
      DEC_HAZ:   state_to_mode = MODE_HAZARD;
      default:   state_to_mode = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/vlc_hold_timer.sv
// Saturating hold timer: counts cycles since the last clear and flags the
// moment the count reaches TIMEOUT. It stays saturated afterwards, so the
// flag fires once per held pattern.
module vlc_hold_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] hold_cnt;

  // Count up from zero after each clear, stopping at LIMIT.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || clear) begin
      hold_cnt <= '0;
    end else if (hold_cnt != LIMIT) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // High during the cycle whose closing edge brings the count to LIMIT, so
  // the owner acts on that same edge. A clear in that cycle takes priority.
  assign expired = !clear && (hold_cnt == LIMIT - CNT_W'(1));

endmodule

// File: rtl/vlc_lamp_decoder.sv
// Tail-lamp pattern decoder: rebuilds the controller mode from the six lamp
// lines, flags illegal transitions and stuck patterns, and counts errors.
module vlc_lamp_decoder
  import vlc_pkg::*;
#(
  parameter int LOCK_STEPS = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] left_lamp,
  input  logic [2:0] right_lamp,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       err,
  output logic [7:0] err_count,
  output logic       stuck
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_STEPS);

  vlc_dec_state_t state, state_nx, tgt;
  vlc_pattern_t   pattern, cur, cur_nx;
  logic [3:0]     lock_cnt, lock_nx, lock_inc;
  logic           change, expired, err_hit, stuck_nx;

  assign pattern = {left_lamp, right_lamp};
  assign change  = (pattern != cur);

  vlc_hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (change),
    .expired (expired)
  );

  // Classify the current cycle: pattern change, hold expiry, or nothing.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    cur_nx   = cur;
    lock_nx  = lock_cnt;
    stuck_nx = stuck;
    err_hit  = 1'b0;
    tgt      = DEC_ACQ;
    lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 4'd1;

    if (change) begin
      cur_nx   = pattern;
      stuck_nx = 1'b0;
      if (cur == PAT_OFF) begin
        // Leaving OFF: only the first step of a sequence is acceptable.
        case (pattern)
          PAT_L1:  tgt = DEC_LEFT;
          PAT_R1:  tgt = DEC_RIGHT;
          PAT_HAZ: tgt = DEC_HAZ;
          default: tgt = DEC_ACQ;
        endcase
        if (tgt == DEC_ACQ) begin
          err_hit = 1'b1;
        end else begin
          lock_nx  = (tgt == state) ? lock_inc : 4'd1;
          state_nx = tgt;
        end
      end else if (state == DEC_ACQ) begin
        // Not following a mode: wait for OFF before re-acquiring.
        err_hit = (pattern != PAT_OFF);
      end else if (pattern == next_step(state, cur)) begin
        // Next step of the sequence, including the terminal return to OFF.
        lock_nx = lock_inc;
      end else if (pattern == PAT_OFF) begin
        // Sequence cut short; benign, but the mode is no longer known.
        lock_nx  = '0;
        state_nx = DEC_ACQ;
      end else begin
        err_hit = 1'b1;
      end

      if (err_hit) begin
        lock_nx  = '0;
        state_nx = DEC_ACQ;
      end
    end else if (expired) begin
      if (cur != PAT_OFF) begin
        // A lit pattern held too long: the lamps are stuck.
        err_hit  = 1'b1;
        stuck_nx = 1'b1;
        lock_nx  = '0;
      end else begin
        // Lamps dark for the whole window: a trustworthy IDLE.
        state_nx = DEC_ACQ;
        lock_nx  = LOCK_MAX;
      end
    end
  end

  // Register tracking state and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DEC_ACQ;
      cur        <= PAT_OFF;
      lock_cnt   <= '0;
      mode       <= MODE_IDLE;
      mode_valid <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      stuck      <= 1'b0;
    end else begin
      state      <= state_nx;
      cur        <= cur_nx;
      lock_cnt   <= lock_nx;
      mode       <= state_to_mode(state_nx);
      mode_valid <= (lock_nx == LOCK_MAX);
      err        <= err_hit;
      stuck      <= stuck_nx;
      if (err_hit && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vlc_lamp_decoder.sv
// Self-checking bench for vlc_lamp_decoder: directed scenarios followed by
// randomized lamp traffic, all compared against a sequence-level model.
module tb_vlc_lamp_decoder;

  localparam int LOCK = 4;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] left_lamp  = 3'b000;
  logic [2:0] right_lamp = 3'b000;
  logic [1:0] mode;
  logic       mode_valid;
  logic       err;
  logic [7:0] err_count;
  logic       stuck;

  always #5 clk = ~clk;

  vlc_lamp_decoder #(
    .LOCK_STEPS (LOCK),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .left_lamp  (left_lamp),
    .right_lamp (right_lamp),
    .mode       (mode),
    .mode_valid (mode_valid),
    .err        (err),
    .err_count  (err_count),
    .stuck      (stuck)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: patterns as integers {left,right}, mode 0 = idle/acquire.
  int m_cur   = 0;
  int m_mode  = 0;
  int m_lock  = 0;
  int m_age   = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  bit m_stuck = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Successor of prev in the lamp sequence of a mode; -1 if prev is not in it.
  function automatic int next_in_seq(input int md, input int prev);
    int s[$];
    case (md)
      1:       s = '{8, 24, 56, 0};
      2:       s = '{1, 3, 7, 0};
      default: s = '{63, 0};
    endcase
    foreach (s[i]) if (s[i] == prev) return s[(i + 1) % s.size()];
    return -1;
  endfunction

  task automatic model(input int p, input bit r);
    int  prev;
    int  tgt;
    bit  illegal;
    m_err   = 1'b0;
    illegal = 1'b0;
    if (r) begin
      m_cur = 0; m_mode = 0; m_lock = 0; m_age = 0; m_cnt = 0; m_stuck = 1'b0;
      return;
    end
    if (p != m_cur) begin
      prev    = m_cur;
      m_cur   = p;
      m_age   = 0;
      m_stuck = 1'b0;
      if (prev == 0) begin
        tgt = (p == 8) ? 1 : (p == 1) ? 2 : (p == 63) ? 3 : 0;
        if (tgt == 0) illegal = 1'b1;
        else begin
          m_lock = (tgt == m_mode) ? ((m_lock < LOCK) ? m_lock + 1 : LOCK) : 1;
          m_mode = tgt;
        end
      end else if (m_mode == 0) begin
        illegal = (p != 0);
      end else if (p == next_in_seq(m_mode, prev)) begin
        m_lock = (m_lock < LOCK) ? m_lock + 1 : LOCK;
      end else if (p == 0) begin
        m_lock = 0;
        m_mode = 0;
      end else begin
        illegal = 1'b1;
      end
      if (illegal) begin
        m_err  = 1'b1;
        m_lock = 0;
        m_mode = 0;
      end
    end else if (m_age < TMO) begin
      m_age++;
      if (m_age == TMO) begin
        if (m_cur != 0) begin
          m_err = 1'b1; m_stuck = 1'b1; m_lock = 0;
        end else begin
          m_mode = 0; m_lock = LOCK;
        end
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  // One clock: drive inputs, advance the model, sample just after the edge.
  task automatic tick(input int p, input bit r = 1'b0);
    {left_lamp, right_lamp} = p[5:0];
    rst = r;
    model(p, r);
    @(posedge clk);
    #1;
    check("mode",       mode,       m_mode);
    check("mode_valid", mode_valid, (m_lock == LOCK));
    check("err",        err,        m_err);
    check("err_count",  err_count,  m_cnt);
    check("stuck",      stuck,      m_stuck);
  endtask

  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) tick(p);
  endtask

  initial begin
    int errs;
    int err_at;
    int pool[8];
    int p;
    int len;
    pool = '{0, 8, 24, 56, 1, 3, 7, 63};

    // Reset state.
    tick(0, 1'b1);
    tick(0, 1'b1);
    check("rst_mode", mode, 0);
    check("rst_valid", mode_valid, 0);
    check("rst_count", err_count, 0);

    // OFF held a full window locks IDLE.
    hold(0, TMO);
    check("idle_mode", mode, 0);
    check("idle_valid", mode_valid, 1);

    // Left sequence, each step held 4 cycles.
    hold(8, 4); hold(24, 4); hold(56, 4);
    tick(0);
    check("left_mode", mode, 1);
    check("left_valid", mode_valid, 1);
    check("left_count", err_count, 0);
    hold(0, 3);

    // Hazard: four steps lock, then a left start restarts the lock.
    hold(63, 3); hold(0, 3); hold(63, 3);
    tick(0);
    check("haz_mode", mode, 3);
    check("haz_valid", mode_valid, 1);
    hold(0, 2);
    tick(8);
    check("haz_relock", mode_valid, 0);
    hold(8, 3);

    // Illegal jump 001 -> 111 on the left side.
    tick(56);
    check("jump_err", err, 1);
    check("jump_count", err_count, 1);
    check("jump_valid", mode_valid, 0);
    tick(56);
    check("jump_err_1cyc", err, 0);
    hold(0, 3);
    hold(8, 3);
    check("reacq_mode", mode, 1);

    // Stuck pattern: 011/000 held 40 cycles after the change.
    tick(0, 1'b1);
    tick(8);
    tick(24);
    errs   = 0;
    err_at = -1;
    for (int k = 1; k < 40; k++) begin
      tick(24);
      if (err === 1'b1) begin
        errs++;
        err_at = k;
      end
    end
    check("stuck_pulses", errs, 1);
    check("stuck_at", err_at, TMO);
    check("stuck_flag", stuck, 1);
    check("stuck_count", err_count, 1);
    tick(56);
    check("stuck_clear", stuck, 0);

    // Abort: 011/000 -> OFF is benign.
    hold(0, 2); tick(8); tick(24);
    tick(0);
    check("abort_err", err, 0);
    check("abort_valid", mode_valid, 0);

    // 260 illegal transitions saturate the counter.
    tick(56);
    for (int i = 1; i < 260; i++) tick((i % 2) ? 24 : 56);
    check("sat_count", err_count, 255);

    // Reset one cycle in the middle of a left sequence.
    tick(0); tick(8); tick(24);
    tick(24, 1'b1);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_valid", mode_valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_count", err_count, 0);
    check("mid_rst_stuck", stuck, 0);
    tick(24);

    // Randomized traffic, biased toward legal continuations.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        if (m_cur == 0)       p = pool[$urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) ? 4 : 7)];
        else if (m_mode != 0) p = next_in_seq(m_mode, m_cur);
        else                  p = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        p = int'($urandom_range(0, 63));
      end else begin
        p = pool[$urandom_range(0, 7)];
      end
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 4));
      if ($urandom_range(0, 39) == 0) tick(p, 1'b1);
      hold(p, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
